// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write port shared by pipeline WB and a long-latency FIFO.
// Optional trace output: define WB_ARB_TRACE_EN to print each write and each stall request.
`timescale 1ns/1ps
module wb_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_we_i,
    input  logic [4:0]               pipe_rd_i,
    input  logic [WIDTH-1:0]         pipe_data_i,
    input  logic                     lu_valid_i,
    input  logic [4:0]               lu_rd_i,
    input  logic [WIDTH-1:0]         lu_data_i,
    output logic                     lu_ready_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [WIDTH-1:0]         rf_wdata_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     stall_req_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_mem_rd   [DEPTH];
    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [GW-1:0]    r_age;

    logic w_busy;
    logic w_empty;
    logic w_deq;
    logic w_enq;

    // A pipe write to x0 is a free slot the FIFO may use.
    assign w_busy       = pipe_we_i && (pipe_rd_i != 5'd0);
    assign w_empty      = (r_count == '0);
    assign w_deq        = !w_busy && !w_empty;
    assign lu_ready_o   = (r_count < CW'(DEPTH));
    assign w_enq        = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0);
    assign fifo_count_o = r_count;
    assign stall_req_o  = (r_age >= GW'(STARVE_LIMIT));

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + AW'(1);
            if (w_deq) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_rd[r_wptr]   <= lu_rd_i;
            r_mem_data[r_wptr] <= lu_data_i;
        end
    end

    // Head age: counts waiting cycles, saturating at the starvation limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (w_empty || w_deq) begin
            r_age <= '0;
        end else if (!stall_req_o) begin
            r_age <= r_age + GW'(1);
        end
    end

    // Registered write port: pipe first, else FIFO head, else idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (w_busy) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= pipe_rd_i;
            rf_wdata_o <= pipe_data_i;
        end else if (w_deq) begin
            rf_we_o    <= 1'b1;
            rf_waddr_o <= r_mem_rd[r_rptr];
            rf_wdata_o <= r_mem_data[r_rptr];
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

`ifdef WB_ARB_TRACE_EN
    logic r_trc_lu;
    logic r_trc_stall;

    // Remember write source and previous stall level for the trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trc_lu    <= 1'b0;
            r_trc_stall <= 1'b0;
        end else begin
            r_trc_lu    <= w_deq;
            r_trc_stall <= stall_req_o;
        end
    end

    // Print each committed write and each stall request rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (rf_we_o)
                $display("wb_arb: %s rd=%0d data=%h count=%0d",
                         r_trc_lu ? "LU" : "PIPE",
                         rf_waddr_o, rf_wdata_o, r_count);
            if (stall_req_o && !r_trc_stall)
                $display("wb_arb: stall request, count=%0d", r_count);
        end
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table, corner sequences and random traffic
// checked against a queue-based model of the write-port arbiter.
`timescale 1ns/1ps
module tb_wb_port_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [2:0]  fifo_count_o;
    logic        stall_req_o;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pipe_we_i(pipe_we_i),
        .pipe_rd_i(pipe_rd_i),
        .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i),
        .lu_rd_i(lu_rd_i),
        .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o),
        .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o),
        .fifo_count_o(fifo_count_o),
        .stall_req_o(stall_req_o)
    );

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [13];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of pending {rd,data}; head wait measured from when it became head.
    logic [36:0] q [$];
    int          cyc = 0;
    int          head_since = 0;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        head_since = cyc;
    endtask

    task automatic model_cycle();
        bit          busy;
        bit          was_empty;
        bit          deq;
        bit          enq;
        logic [36:0] h;
        busy      = pipe_we_i && (pipe_rd_i != 0);
        was_empty = (q.size() == 0);
        deq       = !busy && !was_empty;
        enq       = lu_valid_i && (q.size() < DEPTH) && (lu_rd_i != 0);
        if (busy) begin
            m_we = 1'b1;
            m_wa = pipe_rd_i;
            m_wd = pipe_data_i;
        end else if (deq) begin
            h    = q.pop_front();
            m_we = 1'b1;
            m_wa = h[36:32];
            m_wd = h[31:0];
        end else begin
            m_we = 1'b0;
        end
        if (enq) q.push_back({lu_rd_i, lu_data_i});
        if ((deq || was_empty) && q.size() > 0) head_since = cyc + 1;
    endtask

    function automatic bit exp_stall();
        return (q.size() > 0) && ((cyc - head_since) >= LIMIT);
    endfunction

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        pipe_we_i   = pwe;
        pipe_rd_i   = prd;
        pipe_data_i = pdat;
        lu_valid_i  = lv;
        lu_rd_i     = lrd;
        lu_data_i   = ldat;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_we"},    rf_we_o,      m_we);
        chk({tag, "_waddr"}, rf_waddr_o,   m_wa);
        chk({tag, "_wdata"}, rf_wdata_o,   m_wd);
        chk({tag, "_count"}, fifo_count_o, q.size());
        chk({tag, "_stall"}, stall_req_o,  exp_stall());
        chk({tag, "_ready"}, lu_ready_o,   q.size() < DEPTH);
    endtask

    initial begin
        int          nxt;
        bit          acc;
        logic [4:0]  got [$];
        int          prob;

        tbl[0]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  32'h55,   1'b0, 5'd0,  32'h0,    3'd1};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  32'h55,   3'd0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd3,  32'h55,   3'd0};
        tbl[3]  = '{1'b1, 5'd0,  32'h99,   1'b1, 5'd9,  32'h900,  1'b0, 5'd3,  32'h55,   3'd1};
        tbl[4]  = '{1'b1, 5'd0,  32'h77,   1'b1, 5'd0,  32'hdead, 1'b1, 5'd9,  32'h900,  3'd0};
        tbl[5]  = '{1'b1, 5'd5,  32'hAAAA, 1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'hAAAA, 3'd0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hbeef, 1'b0, 5'd5,  32'hAAAA, 3'd0};
        tbl[7]  = '{1'b1, 5'd5,  32'hAAAA, 1'b1, 5'd7,  32'h1234, 1'b1, 5'd5,  32'hAAAA, 3'd1};
        tbl[8]  = '{1'b1, 5'd6,  32'hBBBB, 1'b1, 5'd8,  32'h88,   1'b1, 5'd6,  32'hBBBB, 3'd2};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 32'hA0,   1'b1, 5'd7,  32'h1234, 3'd2};
        tbl[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd8,  32'h88,   3'd1};
        tbl[11] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 32'hA0,   3'd0};
        tbl[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd10, 32'hA0,   3'd0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Vector table: latency, x0 handling, priority, simultaneous enq/deq
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].pwe, tbl[i].prd, tbl[i].pdat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
            step();
            chk($sformatf("tbl%0d_we", i),    rf_we_o,      tbl[i].we);
            chk($sformatf("tbl%0d_waddr", i), rf_waddr_o,   tbl[i].wa);
            chk($sformatf("tbl%0d_wdata", i), rf_wdata_o,   tbl[i].wd);
            chk($sformatf("tbl%0d_count", i), fifo_count_o, tbl[i].cnt);
        end

        // Starvation: pipe keeps the port busy, LU result waits
        drive(1, 5, 32'hAAAA, 1, 7, 32'h1234);
        step();
        check_all("starve_enq");
        drive(1, 5, 32'hAAAA, 0, 0, 0);
        repeat (10) begin
            step();
            check_all("starve");
        end
        chk("starve_count", fifo_count_o, 1);
        chk("starve_stall", stall_req_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_all("starve_drain");
        chk("drain_we", rf_we_o, 1);
        chk("drain_rd", rf_waddr_o, 7);
        chk("drain_data", rf_wdata_o, 32'h1234);
        chk("stall_drop", stall_req_o, 0);

        // Full FIFO and pointer wrap
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5, 32'h55, 1, 5'(i), 32'h100 + 32'(i));
            step();
            check_all("fill");
        end
        chk("full_count", fifo_count_o, 4);
        chk("full_ready", lu_ready_o, 0);
        drive(1, 5, 32'h55, 1, 5, 32'h105);
        step();
        chk("full_held", fifo_count_o, 4);
        nxt = 5;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, 0, nxt <= 10, 5'(nxt), 32'h100 + 32'(nxt));
            acc = lu_ready_o && (nxt <= 10);
            step();
            check_all("wrap");
            if (c == 0) chk("full_deq_no_enq", fifo_count_o, 3);
            if (rf_we_o) got.push_back(rf_waddr_o);
            if (acc) nxt++;
        end
        chk("order_len", got.size(), 10);
        for (int k = 0; k < got.size() && k < 10; k++)
            chk($sformatf("order%0d", k), got[k], k + 1);

        // Reset mid-operation with two entries queued
        drive(1, 6, 32'h66, 1, 11, 32'hB11);
        step();
        drive(1, 6, 32'h66, 1, 12, 32'hB12);
        step();
        check_all("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_we", rf_we_o, 0);
        chk("arst_waddr", rf_waddr_o, 0);
        chk("arst_wdata", rf_wdata_o, 0);
        chk("arst_count", fifo_count_o, 0);
        chk("arst_stall", stall_req_o, 0);
        chk("arst_ready", lu_ready_o, 1);
        drive(0, 0, 0, 1, 13, 32'hB13);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_hs", fifo_count_o, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) begin
            step();
            check_all("post_reset");
            chk("post_reset_nowr", rf_we_o, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            prob = ((i / 100) % 2 == 1) ? 90 : 40;
            drive($urandom_range(0, 99) < prob,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom,
                  $urandom_range(0, 99) < 40,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom);
            step();
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
